// File: rtl/arbitro_qos_pkg.sv
// Shared types and constants for the arbitro_qos class-steering arbiter.
// FSM encodings, stall-mode selectors and default widths.
package arbitro_qos_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2
  } state_e;

  localparam int unsigned ModeGlobal   = 0;
  localparam int unsigned ModePerClass = 1;

  localparam int unsigned DefDataW  = 12;
  localparam int unsigned DefClassW = 2;
  localparam int unsigned DefNumCh  = 4;
  localparam int unsigned DefCntW   = 8;

endpackage

// File: rtl/arb_class_decoder.sv
// Extracts the class field from the word MSBs and converts it to a one-hot channel select.
module arb_class_decoder
  import arbitro_qos_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CLASS_W = DefClassW
) (
  input  logic [DATA_W-1:0]       word,
  output logic [CLASS_W-1:0]      cls,
  output logic [2**CLASS_W-1:0]   onehot
);

  assign cls = word[DATA_W-1 -: CLASS_W];

  always_comb begin
    onehot      = '0;
    onehot[cls] = 1'b1;
  end

  // Payload bits are carried by the top, not needed here.
  logic unused_payload;
  assign unused_payload = ^word[DATA_W-CLASS_W-1:0];

endmodule

// File: rtl/arbitro_qos.sv
// QoS arbiter: drains a FWFT input FIFO into per-class FIFOs with registered push/data.
// Optional per-channel push statistics are built when ARB_STATS_EN is defined.
module arbitro_qos
  import arbitro_qos_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CLASS_W = DefClassW,
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned MODE    = ModeGlobal,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       demuxin,
  input  logic                    emptyFIFO,
  input  logic [NUM_CH-1:0]       almost_fullFIFO,
  output logic                    pop,
  output logic [NUM_CH-1:0]       push,
  output logic [DATA_W-1:0]       data_out,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    idle,
  output logic [NUM_CH*CNT_W-1:0] stats
);

  state_e              state_q, state_d;
  logic [CLASS_W-1:0]  cls;
  logic [NUM_CH-1:0]   cls_oh;
  logic                blk;
  logic [NUM_CH-1:0]   push_q, push_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                stall_q, idle_q;

  arb_class_decoder #(
    .DATA_W  (DATA_W),
    .CLASS_W (CLASS_W)
  ) u_dec (
    .word   (demuxin),
    .cls    (cls),
    .onehot (cls_oh)
  );

  assign blk = (MODE == ModePerClass) ? almost_fullFIFO[cls] : |almost_fullFIFO;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun: begin
        pop = !emptyFIFO && !blk;
        if (!emptyFIFO && blk) state_d = StStall;
      end
      StStall: begin
        // Leaving STALL and popping can happen in the same cycle.
        pop = !emptyFIFO && !blk;
        if (emptyFIFO || !blk) state_d = StRun;
      end
      default: state_d = StInit;
    endcase
    if (!reset) pop = 1'b0;
  end

  always_comb begin
    push_d      = pop ? cls_oh : '0;
    data_d      = pop ? demuxin : data_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) begin
      stall_cnt_d = '0;
    end else if (state_d == StStall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StInit;
      push_q      <= '0;
      data_q      <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= (state_d == StStall);
      idle_q      <= emptyFIFO && (push_d == '0);
    end
  end

  assign push      = push_q;
  assign data_out  = data_q;
  assign stall_cnt = stall_cnt_q;
  assign stall     = stall_q;
  assign idle      = idle_q;

`ifdef ARB_STATS_EN
  logic [NUM_CH*CNT_W-1:0] stats_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stats_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (push_q[i]) stats_q[i*CNT_W +: CNT_W] <= stats_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign stats = stats_q;
`else
  assign stats = '0;
`endif

endmodule

// File: tb/tb_arbitro_qos.sv
// Directed bench for arbitro_qos: one MODE=0 and one MODE=1 instance, scoreboarded push/data.
module tb_arbitro_qos;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din0, din1;
  logic        emp0, emp1;
  logic [3:0]  af0, af1;
  logic        pop0, pop1, stall0, stall1, idle0, idle1;
  logic [3:0]  push0, push1;
  logic [11:0] dout0, dout1;
  logic [7:0]  scnt0, scnt1;
  logic [31:0] stats0, stats1;

  always #5 clk = ~clk;

  arbitro_qos #(.DATA_W(12), .CLASS_W(2), .NUM_CH(4), .MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .demuxin(din0), .emptyFIFO(emp0), .almost_fullFIFO(af0),
    .pop(pop0), .push(push0), .data_out(dout0), .stall(stall0), .stall_cnt(scnt0),
    .idle(idle0), .stats(stats0)
  );

  arbitro_qos #(.DATA_W(12), .CLASS_W(2), .NUM_CH(4), .MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .demuxin(din1), .emptyFIFO(emp1), .almost_fullFIFO(af1),
    .pop(pop1), .push(push1), .data_out(dout1), .stall(stall1), .stall_cnt(scnt1),
    .idle(idle1), .stats(stats1)
  );

  typedef struct {
    logic [3:0]  push;
    logic [11:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] hold0, hold1;
  int          smodel[4];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on instance sel; exp_pop is the bench's own expectation.
  task automatic step(input int sel, input logic exp_pop, input string tag);
    logic [11:0] w;
    exp_t        e;
    #1;
    w = (sel != 0) ? din1 : din0;
    chk({tag, ".pop"}, (sel != 0) ? pop1 : pop0, exp_pop);
    if (exp_pop) begin
      e.push = 4'b0001 << w[11:10];
      e.data = w;
      if (sel == 0) smodel[w[11:10]]++;
    end else begin
      e.push = 4'b0000;
      e.data = (sel != 0) ? hold1 : hold0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel != 0) hold1 = e.data;
    else hold0 = e.data;
    chk({tag, ".push"}, (sel != 0) ? push1 : push0, e.push);
    chk({tag, ".data"}, (sel != 0) ? dout1 : dout0, e.data);
  endtask

  function automatic logic [31:0] exp_stats();
    logic [31:0] s;
    s = '0;
`ifdef ARB_STATS_EN
    for (int c = 0; c < 4; c++) s[c*8 +: 8] = smodel[c][7:0];
`endif
    return s;
  endfunction

  initial begin
    reset = 1'b1;
    din0 = 12'h000; emp0 = 1'b0; af0 = 4'b0000;
    din1 = 12'h000; emp1 = 1'b1; af1 = 4'b0000;
    hold0 = '0; hold1 = '0;
    for (int c = 0; c < 4; c++) smodel[c] = 0;
    #1 reset = 1'b0;
    #2;
    chk("rst.pop", pop0, 1'b0);
    chk("rst.push", push0, 4'b0000);
    chk("rst.idle", idle0, 1'b1);
    chk("rst.stall", stall0, 1'b0);
    chk("rst.scnt", scnt0, 8'd0);
    chk("rst.data", dout0, 12'h000);
    chk("rst.stats", stats0, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold.pop", pop0, 1'b0);
    chk("rst_hold.idle", idle0, 1'b1);
    reset = 1'b1;

    // INIT cycle, then stream one word of each class.
    step(0, 1'b0, "init");
    chk("init.idle", idle0, 1'b0);
    din0 = 12'h000; step(0, 1'b1, "s0");
    din0 = 12'h400; step(0, 1'b1, "s1");
    din0 = 12'h800; step(0, 1'b1, "s2");
    din0 = 12'hC00; step(0, 1'b1, "s3");
    emp0 = 1'b1;    step(0, 1'b0, "drain");
    chk("drain.idle", idle0, 1'b1);

    // MODE=0: any almost-full blocks a class-0 head.
    emp0 = 1'b0; din0 = 12'h055; af0 = 4'b0100;
    step(0, 1'b0, "gst1"); chk("gst1.stall", stall0, 1'b1); chk("gst1.cnt", scnt0, 8'd1);
    step(0, 1'b0, "gst2"); chk("gst2.cnt", scnt0, 8'd2);
    step(0, 1'b0, "gst3"); chk("gst3.cnt", scnt0, 8'd3);
    af0 = 4'b0000;
    step(0, 1'b1, "grel"); chk("grel.stall", stall0, 1'b0); chk("grel.cnt", scnt0, 8'd0);

    // Empty overrides blocking.
    emp0 = 1'b1; af0 = 4'b1111;
    step(0, 1'b0, "emp_blk"); chk("emp_blk.stall", stall0, 1'b0); chk("emp_blk.cnt", scnt0, 8'd0);

    // MODE=1: only the head's own class blocks.
    emp1 = 1'b0; din1 = 12'h055; af1 = 4'b0100;
    step(1, 1'b1, "pc0");
    din1 = 12'h855;
    step(1, 1'b0, "pc_st1"); chk("pc_st1.stall", stall1, 1'b1);
    step(1, 1'b0, "pc_st2"); chk("pc_st2.cnt", scnt1, 8'd2);
    af1 = 4'b0000;
    step(1, 1'b1, "pc_rel"); chk("pc_rel.stall", stall1, 1'b0);
    emp1 = 1'b1;
    step(1, 1'b0, "pc_idle"); chk("pc_idle.idle", idle1, 1'b1);

    // Stall counter saturation.
    emp0 = 1'b0; din0 = 12'h055; af0 = 4'b0001;
    for (int i = 0; i < 300; i++) step(0, 1'b0, "sat");
    chk("sat.cnt", scnt0, 8'd255);
    chk("sat.stall", stall0, 1'b1);
    af0 = 4'b0000;
    step(0, 1'b1, "sat_rel"); chk("sat_rel.cnt", scnt0, 8'd0);

    // Back-to-back class-1 pushes for the statistics counters.
    for (int i = 0; i < 260; i++) begin
      din0 = 12'h400 | 12'(i & 'h3ff);
      step(0, 1'b1, "b2b");
    end
    emp0 = 1'b1;
    step(0, 1'b0, "b2b_end");
    step(0, 1'b0, "b2b_end2");
    chk("stats", stats0, exp_stats());

    // Asynchronous reset between edges while a push is outstanding.
    emp0 = 1'b0; din0 = 12'h4AB;
    step(0, 1'b1, "mid");
    chk("mid.push", push0, 4'b0010);
    #2 reset = 1'b0;
    #1;
    chk("arst.push", push0, 4'b0000);
    chk("arst.data", dout0, 12'h000);
    chk("arst.pop", pop0, 1'b0);
    chk("arst.idle", idle0, 1'b1);
    chk("arst.stats", stats0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    hold0 = '0; hold1 = '0;
    for (int c = 0; c < 4; c++) smodel[c] = 0;
    step(0, 1'b0, "re_init");
    step(0, 1'b1, "re_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
